fetch_pc_ctrl: RTL

//  Owns the PC register and the IF/ID pipeline register of the 5-stage MIPS core.

---
 rtl/fetch_pc_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/fetch_pc_ctrl.sv
// PC register and IF/ID pipeline register of the 5-stage MIPS core.
// Redirects for branches and j/jal/jr/jalr keep one delay slot that is never squashed.
module fetch_pc_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] rs_val,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        pc_err
);

  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [31:0] pc4_d;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] npc;
  logic        npc_bad;

  assign op     = instr_d[31:26];
  assign rt     = instr_d[20:16];
  assign funct  = instr_d[5:0];
  assign pc4_d  = pc_d + 32'd4;
  assign br_tgt = pc4_d + {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
  assign j_tgt  = {pc4_d[31:28], instr_d[25:0], 2'b00};
  assign pc8_d  = pc_d + 32'd8;

  // Redirect is decoded purely from the instruction currently held in ID.
  always_comb begin
    npc = pc_f + 32'd4;
    case (op)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        if (br_taken) npc = br_tgt;
      end
      OP_REGIMM: begin
        if (br_taken && (rt[4:1] == 4'd0)) npc = br_tgt;
      end
      OP_J, OP_JAL: npc = j_tgt;
      OP_SPECIAL: begin
        if ((funct == FN_JR) || (funct == FN_JALR)) npc = rs_val;
      end
      default: npc = pc_f + 32'd4;
    endcase
  end

  assign npc_bad = (npc[1:0] != 2'b00) ||
                   ({1'b0, npc} < {1'b0, IM_BASE}) ||
                   ({1'b0, npc} >= IM_END);

  // stall=1 holds the whole front end (PC and IF/ID) for that cycle; the
  // redirect is recomputed from the held instr_d once stall drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f    <= PC_RESET;
      instr_d <= 32'd0;
      pc_d    <= PC_RESET;
      pc_err  <= 1'b0;
    end else if (!stall) begin
      pc_f    <= npc;
      instr_d <= im_rdata;
      pc_d    <= pc_f;
      if (npc_bad) pc_err <= 1'b1;
    end
  end

endmodule
